// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline (load-use,
//               taken-branch flush, imem/dmem waits with watchdog).
//               Optional performance counters enabled by macro HAZ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int BR_PENALTY  = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr,
  input  logic [REG_ADDR_W-1:0] id_sw_addr,
  input  logic                  id_reg1_read,
  input  logic                  id_reg2_read,
  input  logic                  id_sw_read,
  input  logic [REG_ADDR_W-1:0] exe_write_addr,
  input  logic                  exe_reg_write,
  input  logic                  exe_DM_read,
  input  logic                  exe_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_exe,
  output logic                  stall_exe_mem,
  output logic                  stall_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_BR_FLUSH = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [1:0]        C_BR_RELOAD = 2'(BR_PENALTY - 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        r_saved_state;
  logic [1:0]        w_eff_state;
  logic [1:0]        r_br_cnt;
  logic [1:0]        w_br_cnt_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic              w_dwait;
  logic              w_load_use;

  assign w_dwait    = dmem_req & ~dmem_ready;
  assign w_load_use = exe_DM_read & exe_reg_write &
                      ((id_reg1_read & (id_reg1_addr == exe_write_addr)) |
                       (id_reg2_read & (id_reg2_addr == exe_write_addr)) |
                       (id_sw_read   & (id_sw_addr   == exe_write_addr)));

  // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
  assign w_eff_state = (r_state == S_MEM_WAIT) ? r_saved_state : r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_saved_state <= S_RUN;
      r_br_cnt      <= 2'd0;
    end else begin
      r_state  <= w_next_state;
      r_br_cnt <= w_br_cnt_next;
      if (w_dwait && (r_state != S_MEM_WAIT))
        r_saved_state <= r_state;
    end
  end

  always_comb begin
    w_next_state  = w_eff_state;
    w_br_cnt_next = r_br_cnt;
    if (w_dwait) begin
      w_next_state = S_MEM_WAIT;
    end else if (exe_branch_taken) begin
      w_br_cnt_next = C_BR_RELOAD;
      w_next_state  = (C_BR_RELOAD == 2'd0) ? S_RUN : S_BR_FLUSH;
    end else if ((w_eff_state == S_BR_FLUSH) && imem_ready) begin
      if (r_br_cnt <= 2'd1) begin
        w_br_cnt_next = 2'd0;
        w_next_state  = S_RUN;
      end else begin
        w_br_cnt_next = r_br_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_exe  = 1'b0;
    stall_exe_mem = 1'b0;
    stall_mem_wb  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_exe  = 1'b0;
    if (rst) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (w_dwait) begin
      stall_pc      = 1'b1;
      stall_if_id   = 1'b1;
      stall_id_exe  = 1'b1;
      stall_exe_mem = 1'b1;
      stall_mem_wb  = 1'b1;
    end else if (exe_branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (w_eff_state == S_BR_FLUSH) begin
      flush_if_id = 1'b1;
      stall_pc    = ~imem_ready;
    end else if (w_load_use || !imem_ready) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end
  end

  // Watchdog: consecutive dmem wait cycles, sticky flag until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_dwait) begin
      if (r_wait_cnt != C_WAIT_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == C_WAIT_MAX - 1'b1)
        r_mem_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (stall_pc && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 1'b1;
      if ((flush_if_id || flush_id_exe) && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//               randomized traffic against a behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int RW   = 5;
  localparam int BRP  = 2;
  localparam int MTO  = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_reg1_addr, id_reg2_addr, id_sw_addr, exe_write_addr;
  logic          id_reg1_read, id_reg2_read, id_sw_read;
  logic          exe_reg_write, exe_DM_read, exe_branch_taken;
  logic          imem_ready, dmem_req, dmem_ready;
  logic          stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb;
  logic          flush_if_id, flush_id_exe, mem_timeout;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W (RW),
    .BR_PENALTY (BRP),
    .MEM_TIMEOUT(MTO),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_addr    (id_reg1_addr),
    .id_reg2_addr    (id_reg2_addr),
    .id_sw_addr      (id_sw_addr),
    .id_reg1_read    (id_reg1_read),
    .id_reg2_read    (id_reg2_read),
    .id_sw_read      (id_sw_read),
    .exe_write_addr  (exe_write_addr),
    .exe_reg_write   (exe_reg_write),
    .exe_DM_read     (exe_DM_read),
    .exe_branch_taken(exe_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .stall_id_exe    (stall_id_exe),
    .stall_exe_mem   (stall_exe_mem),
    .stall_mem_wb    (stall_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_exe    (flush_id_exe),
    .mem_timeout     (mem_timeout),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: wrong-path fetches still to squash, wait run length, flags.
  int m_flush_left = 0;
  int m_wait       = 0;
  bit m_timeout    = 1'b0;
  int m_perf_stall = 0;
  int m_perf_flush = 0;
  bit compare_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb, flush_if_id, flush_id_exe}
  function automatic logic [6:0] model_out();
    bit dw, lu;
    dw = dmem_req && !dmem_ready;
    lu = exe_DM_read && exe_reg_write &&
         ((id_reg1_read && id_reg1_addr == exe_write_addr) ||
          (id_reg2_read && id_reg2_addr == exe_write_addr) ||
          (id_sw_read   && id_sw_addr   == exe_write_addr));
    if (rst)                      return 7'b00000_11;
    if (dw)                       return 7'b11111_00;
    if (exe_branch_taken)         return 7'b00000_11;
    if (m_flush_left > 0)         return {!imem_ready, 4'b0000, 2'b10};
    if (lu || !imem_ready)        return 7'b11000_01;
    return 7'b0;
  endfunction

  task automatic compare_all();
    logic [6:0] e;
    e = model_out();
    chk("stall_pc",      32'(stall_pc),      32'(e[6]));
    chk("stall_if_id",   32'(stall_if_id),   32'(e[5]));
    chk("stall_id_exe",  32'(stall_id_exe),  32'(e[4]));
    chk("stall_exe_mem", 32'(stall_exe_mem), 32'(e[3]));
    chk("stall_mem_wb",  32'(stall_mem_wb),  32'(e[2]));
    chk("flush_if_id",   32'(flush_if_id),   32'(e[1]));
    chk("flush_id_exe",  32'(flush_id_exe),  32'(e[0]));
    chk("mem_timeout",   32'(mem_timeout),   rst ? 32'd0 : 32'(m_timeout));
`ifdef HAZ_PERF_EN
    chk("perf_stall_cnt", 32'(perf_stall_cnt), rst ? 32'd0 : 32'(m_perf_stall));
    chk("perf_flush_cnt", 32'(perf_flush_cnt), rst ? 32'd0 : 32'(m_perf_flush));
`else
    chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'd0);
    chk("perf_flush_cnt", 32'(perf_flush_cnt), 32'd0);
`endif
  endtask

  always @(posedge clk) begin
    logic [6:0] e;
    if (rst) begin
      m_flush_left = 0;
      m_wait       = 0;
      m_timeout    = 1'b0;
      m_perf_stall = 0;
      m_perf_flush = 0;
    end else begin
      e = model_out();
      if (e[6] && m_perf_stall < CMAX)             m_perf_stall++;
      if ((e[1] || e[0]) && m_perf_flush < CMAX)   m_perf_flush++;
      if (dmem_req && !dmem_ready) begin
        m_wait++;
        if (m_wait >= MTO) m_timeout = 1'b1;
      end else begin
        m_wait = 0;
        if (exe_branch_taken)                    m_flush_left = BRP - 1;
        else if (m_flush_left > 0 && imem_ready) m_flush_left--;
      end
    end
  end

  always @(negedge clk) if (compare_on) compare_all();

  task automatic idle();
    id_reg1_addr = '0; id_reg2_addr = '0; id_sw_addr = '0; exe_write_addr = '0;
    id_reg1_read = 0;  id_reg2_read = 0;  id_sw_read = 0;
    exe_reg_write = 0; exe_DM_read = 0;   exe_branch_taken = 0;
    imem_ready = 1;    dmem_req = 0;      dmem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("reset_stall_pc",    32'(stall_pc),    32'd0);
    chk("reset_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("reset_flush_id_exe",32'(flush_id_exe),32'd1);
    step(); step();
    rst = 1'b0;
    compare_on = 1'b1;
    step();

    // Load-use on reg2: one-cycle bubble
    exe_DM_read = 1; exe_reg_write = 1; exe_write_addr = 5;
    id_reg2_read = 1; id_reg2_addr = 5;
    at_neg();
    chk("lu_stall_pc", 32'(stall_pc), 32'd1);
    chk("lu_stall_if_id", 32'(stall_if_id), 32'd1);
    chk("lu_flush_id_exe", 32'(flush_id_exe), 32'd1);
    chk("lu_stall_id_exe", 32'(stall_id_exe), 32'd0);
    step(); idle();
    at_neg();
    chk("lu_after_stall_pc", 32'(stall_pc), 32'd0);
    chk("lu_after_flush_id_exe", 32'(flush_id_exe), 32'd0);

    // Taken branch, imem always ready
    step(); exe_branch_taken = 1;
    at_neg();
    chk("br0_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("br0_flush_id_exe", 32'(flush_id_exe), 32'd1);
    step(); exe_branch_taken = 0;
    at_neg();
    chk("br1_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("br1_flush_id_exe", 32'(flush_id_exe), 32'd0);
    step();
    at_neg();
    chk("br2_flush_if_id", 32'(flush_if_id), 32'd0);

    // Branch followed by 3 imem wait cycles
    step(); exe_branch_taken = 1;
    step(); exe_branch_taken = 0; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("brw_flush_if_id", 32'(flush_if_id), 32'd1);
      chk("brw_stall_pc", 32'(stall_pc), 32'd1);
      step();
    end
    imem_ready = 1;
    at_neg();
    chk("brw_ready_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("brw_ready_stall_pc", 32'(stall_pc), 32'd0);
    step();
    at_neg();
    chk("brw_run_flush_if_id", 32'(flush_if_id), 32'd0);

    // Dmem wait in the middle of a branch flush
    step(); exe_branch_taken = 1;
    step(); exe_branch_taken = 0; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("dw_stall_mem_wb", 32'(stall_mem_wb), 32'd1);
      chk("dw_flush_if_id", 32'(flush_if_id), 32'd0);
      step();
    end
    dmem_req = 0; dmem_ready = 1;
    at_neg();
    chk("dw_resume_flush_if_id", 32'(flush_if_id), 32'd1);
    step();
    at_neg();
    chk("dw_done_flush_if_id", 32'(flush_if_id), 32'd0);

    // Watchdog: 10 wait cycles against MEM_TIMEOUT=8
    step(); dmem_req = 1; dmem_ready = 0;
    for (int k = 1; k <= 10; k++) begin
      at_neg();
      if (k == 8) chk("to_before", 32'(mem_timeout), 32'd0);
      if (k == 9) chk("to_after",  32'(mem_timeout), 32'd1);
      step();
    end
    dmem_req = 0; dmem_ready = 1;
    step();
    at_neg();
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    // Branch beats load-use, then async reset during a dmem wait
    step();
    exe_branch_taken = 1; exe_DM_read = 1; exe_reg_write = 1;
    exe_write_addr = 3; id_reg1_read = 1; id_reg1_addr = 3;
    at_neg();
    chk("brlu_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("brlu_stall_pc", 32'(stall_pc), 32'd0);
    step(); idle(); dmem_req = 1; dmem_ready = 0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall_pc", 32'(stall_pc), 32'd0);
    chk("arst_stall_mem_wb", 32'(stall_mem_wb), 32'd0);
    chk("arst_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("arst_mem_timeout", 32'(mem_timeout), 32'd0);
    chk("arst_perf_stall", 32'(perf_stall_cnt), 32'd0);
    chk("arst_perf_flush", 32'(perf_flush_cnt), 32'd0);
    step(); idle();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst              = ($urandom_range(0, 199) == 0);
      id_reg1_addr     = RW'($urandom_range(0, 3));
      id_reg2_addr     = RW'($urandom_range(0, 3));
      id_sw_addr       = RW'($urandom_range(0, 3));
      exe_write_addr   = RW'($urandom_range(0, 3));
      id_reg1_read     = $urandom_range(0, 1);
      id_reg2_read     = $urandom_range(0, 1);
      id_sw_read       = ($urandom_range(0, 3) == 0);
      exe_reg_write    = ($urandom_range(0, 3) != 0);
      exe_DM_read      = ($urandom_range(0, 2) == 0);
      exe_branch_taken = ($urandom_range(0, 6) == 0);
      imem_ready       = ($urandom_range(0, 3) != 0);
      dmem_req         = ($urandom_range(0, 3) == 0);
      dmem_ready       = ($urandom_range(0, 2) == 0);
    end
    step(); idle(); rst = 1'b0;
    step(); step();
    compare_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage AndeStar core (IF/ID/EXE/MEM/WB).
- Sits beside the forwarding unit and drives the stall and flush controls of the PC and every pipeline register.
- Handles three hazard sources:
  - load-use bubbles;
  - taken-branch flush, with a programmable penalty;
  - multi-cycle instruction and data memory waits, with a watchdog timeout.

Parameters:
- REG_ADDR_W, 5: register address width (matches RegAddrBus).
- BR_PENALTY, 2: wrong-path fetch cycles flushed after a taken branch; legal range 1..3.
- MEM_TIMEOUT, 255: consecutive dmem wait cycles before mem_timeout is raised.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- id_reg1_addr, id_reg2_addr, id_sw_addr  in  REG_ADDR_W each  source register addresses in ID.
- id_reg1_read, id_reg2_read, id_sw_read  in  1 each  source-read enables in ID.
- exe_write_addr  in  REG_ADDR_W  destination register in EXE.
- exe_reg_write  in  1  EXE writes the register file.
- exe_DM_read  in  1  EXE instruction is a load.
- exe_branch_taken  in  1  EXE resolved a taken branch or jump.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data access completes this cycle.
- stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb  out  1 each  hold the PC / the named pipeline register.
- flush_if_id, flush_id_exe  out  1 each  load a NOP into the named pipeline register.
- mem_timeout  out  1  sticky error flag.
- perf_stall_cnt, perf_flush_cnt  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- FSM states: RUN, BR_FLUSH, MEM_WAIT. Reset state is RUN.
- Outputs are combinational from the current state and inputs. The only registered outputs are mem_timeout and the perf counters.
- Reset (rst=1, asynchronous):
  - state=RUN, flush counter=0, wait counter=0, mem_timeout=0, perf counters=0;
  - all stall_* = 0; flush_if_id = flush_id_exe = 1.
- Definitions:
  - dwait = dmem_req & ~dmem_ready.
  - load_use = exe_DM_read & exe_reg_write & any source match, where a match is (idX_read & idX_addr == exe_write_addr) for reg1, reg2 or sw.
  - r0 is a normal register; there is no zero-address exemption.
- Priority, highest first: dwait > exe_branch_taken > load_use > ~imem_ready.
- dwait (any state):
  - all five stall_* = 1, both flush_* = 0; state goes to or stays in MEM_WAIT.
  - The wait counter increments while dwait is high. When it reaches MEM_TIMEOUT, mem_timeout is set; it clears only on reset.
  - When dwait drops, the wait counter clears and the FSM returns to the state saved on entry (RUN, or BR_FLUSH with its count preserved).
- exe_branch_taken (no dwait):
  - flush_if_id = 1, flush_id_exe = 1, all stalls 0.
  - Next state BR_FLUSH with remaining count = BR_PENALTY-1. If BR_PENALTY=1, the next state is RUN.
- BR_FLUSH:
  - flush_if_id = 1 each cycle.
  - The count decrements only on cycles with imem_ready=1. On imem_ready=0, additionally assert stall_pc=1.
  - Go to RUN when the count is 0 and imem_ready=1.
  - A new exe_branch_taken in BR_FLUSH reloads the count; ignore load_use in this state.
- load_use (in RUN, no dwait, no branch):
  - stall_pc = 1, stall_if_id = 1, flush_id_exe = 1 for exactly that cycle; state stays RUN.
  - Next cycle the load is in MEM and is covered by forwarding, so the bubble is one cycle.
- ~imem_ready (in RUN, nothing else active): stall_pc = 1, stall_if_id = 1, flush_id_exe = 1. Downstream stages advance.
- Reset asserted mid-MEM_WAIT or mid-BR_FLUSH returns to RUN immediately; the saved state is discarded.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined:
  - perf_stall_cnt counts cycles with stall_pc=1.
  - perf_flush_cnt counts cycles with flush_if_id=1 or flush_id_exe=1, outside reset.
  - Both saturate at 2^CNT_W-1; there is no wrap.
- Undefined: the counter logic is absent and both ports are driven with constant 0.

Test Plan:
- Load-use: exe_DM_read=1, exe_reg_write=1, exe_write_addr=5, id_reg2_read=1, id_reg2_addr=5 for one cycle
  -> stall_pc=1, stall_if_id=1, flush_id_exe=1 for exactly 1 cycle; all outputs 0 the next cycle.
- Taken branch, BR_PENALTY=2, imem_ready=1: pulse exe_branch_taken
  -> flush_if_id=1 for 2 consecutive cycles, flush_id_exe=1 in the first cycle only, then RUN.
- Branch plus imem wait: exe_branch_taken, then imem_ready=0 for 3 cycles
  -> flush_if_id held and stall_pc=1 during the wait; RUN is reached 1 ready cycle after the wait ends.
- Dmem wait during BR_FLUSH: dwait=1 for 4 cycles
  -> all five stalls=1 and flushes=0 during the wait; the remaining flush count resumes afterwards.
- Timeout, MEM_TIMEOUT=8: dwait held for 10 cycles
  -> mem_timeout rises after the 8th wait cycle and stays 1 after dwait drops, until rst.
- Simultaneous branch and load_use, then asynchronous reset mid-MEM_WAIT
  -> the branch flush wins; on reset, outputs go immediately to their reset values, and with HAZ_PERF_EN the counters read 0.
